// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared helpers for the counter bank.
//   prescale_width() - register width for a prescaler counting 0..PRESCALE-1
//   params_ok()      - legal parameter combination check, used at elaboration
package counter_bank_pkg;

  // ceil(log2(prescale)), never below 1 so the register is never zero-width
  function automatic int prescale_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

  function automatic bit params_ok(input int width, input int prescale);
    return (width >= 1) && (prescale >= 1);
  endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// counter_bank_channel: one up/down counter with load, wrap/saturate mode
// and terminal-count flags.
//   clk_i, rst_i      clock, async active-high reset
//   tick_i            shared prescaler strobe
//   load_i            synchronous load (highest priority)
//   load_value_i      load data
//   up_i, enable_i    direction and count enable
//   saturate_i        0 = wrap, 1 = clamp at limits
//   count_o           current value
//   at_max_o/at_min_o combinational terminal flags
//   wrap_pulse_o      registered pulse, high while the wrapped value is shown
module counter_bank_channel #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             up_i,
  input  logic             enable_i,
  input  logic             saturate_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_max_o,
  output logic             at_min_o,
  output logic             wrap_pulse_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_min;

  assign at_max = &count_q;
  assign at_min = ~|count_q;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && tick_i) begin
      if (up_i) begin
        if (!at_max) begin
          count_d = count_q + 1'b1;
        end else if (!saturate_i) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_d = count_q - 1'b1;
        end else if (!saturate_i) begin
          count_d = '1;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o      = count_q;
  assign at_max_o     = at_max;
  assign at_min_o     = at_min;
  assign wrap_pulse_o = wrap_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent up/down counters sharing one prescaler.
//   clock, reset          clock, async active-high reset
//   load, up, enable      per-channel controls
//   load_value            packed load data, channel i at [i*WIDTH +: WIDTH]
//   saturate              global wrap/clamp mode
//   count                 packed counter values, same packing as load_value
//   at_max, at_min        per-channel terminal flags
//   wrap_pulse            per-channel one-cycle wrap indication
//   tick                  prescaler strobe
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               CHANNELS    = 2,
  parameter int               PRESCALE    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      saturate,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       at_max,
  output logic [CHANNELS-1:0]       at_min,
  output logic [CHANNELS-1:0]       wrap_pulse,
  output logic                      tick
);

  if (!params_ok(WIDTH, PRESCALE)) begin : g_bad_params
    $error("counter_bank: WIDTH and PRESCALE must both be >= 1");
  end

  // Divide-by-1 needs no state: tick is simply always high.
  if (PRESCALE == 1) begin : g_no_pre
    assign tick = 1'b1;
  end else begin : g_pre
    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] p_q, p_d;

    assign p_d  = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    assign tick = (p_q == P_LAST);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) p_q <= '0;
      else       p_q <= p_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    counter_bank_channel #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_ch (
      .clk_i        (clock),
      .rst_i        (reset),
      .tick_i       (tick),
      .load_i       (load[i]),
      .load_value_i (load_value[i*WIDTH +: WIDTH]),
      .up_i         (up[i]),
      .enable_i     (enable[i]),
      .saturate_i   (saturate),
      .count_o      (count[i*WIDTH +: WIDTH]),
      .at_max_o     (at_max[i]),
      .at_min_o     (at_min[i]),
      .wrap_pulse_o (wrap_pulse[i])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

  logic       clock, reset, saturate;
  logic [1:0] load, up, enable;
  logic [7:0] load_value;
  logic [7:0] c1, c3;
  logic [1:0] amax1, amin1, wp1, amax3, amin3, wp3;
  logic       tick1, tick3;
  int n_tests = 0;
  int n_fail  = 0;

  counter_bank #(.WIDTH(4), .CHANNELS(2), .PRESCALE(1), .RESET_VALUE(4'd5)) dut (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .up(up), .enable(enable), .saturate(saturate), .count(c1),
    .at_max(amax1), .at_min(amin1), .wrap_pulse(wp1), .tick(tick1));

  counter_bank #(.WIDTH(4), .CHANNELS(2), .PRESCALE(3), .RESET_VALUE(4'd0)) dut3 (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .up(up), .enable(enable), .saturate(saturate), .count(c3),
    .at_max(amax3), .at_min(amin3), .wrap_pulse(wp3), .tick(tick3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_tests++; if (c1 !== 8'h55) begin n_fail++; $display("FAIL reset_count got=%h exp=55", c1); end
    n_tests++; if (amin1 !== 2'b00) begin n_fail++; $display("FAIL reset_at_min got=%b exp=00", amin1); end
    n_tests++; if (amax1 !== 2'b00) begin n_fail++; $display("FAIL reset_at_max got=%b exp=00", amax1); end
    n_tests++; if (wp1 !== 2'b00) begin n_fail++; $display("FAIL reset_wrap got=%b exp=00", wp1); end
    n_tests++; if (tick1 !== 1'b1) begin n_fail++; $display("FAIL reset_tick1 got=%b exp=1", tick1); end
    n_tests++; if (tick3 !== 1'b0) begin n_fail++; $display("FAIL reset_tick3 got=%b exp=0", tick3); end
    n_tests++; if (c3 !== 8'h00) begin n_fail++; $display("FAIL reset_count3 got=%h exp=00", c3); end
    @(negedge clock);
    n_tests++; if (c1 !== 8'h55) begin n_fail++; $display("FAIL reset_hold got=%h exp=55", c1); end
    reset = 1'b0;
  endtask

  task automatic test_wrap_up();
    load = 2'b01; load_value = {4'd0, 4'd14};
    step();
    n_tests++; if (c1 !== 8'h5e) begin n_fail++; $display("FAIL wrap_load got=%h exp=5e", c1); end
    load = 2'b00; up = 2'b11; enable = 2'b01; saturate = 1'b0;
    step();
    n_tests++; if (c1[3:0] !== 4'd15) begin n_fail++; $display("FAIL wrap_15 got=%0d exp=15", c1[3:0]); end
    n_tests++; if (amax1[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_at_max got=%b exp=1", amax1[0]); end
    n_tests++; if (wp1[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_early got=%b exp=0", wp1[0]); end
    step();
    n_tests++; if (c1[3:0] !== 4'd0) begin n_fail++; $display("FAIL wrap_0 got=%0d exp=0", c1[3:0]); end
    n_tests++; if (wp1[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse got=%b exp=1", wp1[0]); end
    n_tests++; if (amin1[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_at_min got=%b exp=1", amin1[0]); end
    step();
    n_tests++; if (c1[3:0] !== 4'd1) begin n_fail++; $display("FAIL wrap_1 got=%0d exp=1", c1[3:0]); end
    n_tests++; if (wp1[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_drop got=%b exp=0", wp1[0]); end
    n_tests++; if (c1[7:4] !== 4'd5) begin n_fail++; $display("FAIL wrap_ch1_hold got=%0d exp=5", c1[7:4]); end
    enable = 2'b00;
  endtask

  task automatic test_sat_down();
    load = 2'b10; load_value = {4'd1, 4'd0};
    step();
    n_tests++; if (c1 !== 8'h11) begin n_fail++; $display("FAIL sat_load got=%h exp=11", c1); end
    load = 2'b00; up = 2'b00; enable = 2'b10; saturate = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++; if (c1[7:4] !== 4'd0) begin n_fail++; $display("FAIL sat_count step=%0d got=%0d exp=0", k, c1[7:4]); end
      n_tests++; if (amin1[1] !== 1'b1) begin n_fail++; $display("FAIL sat_at_min step=%0d got=%b exp=1", k, amin1[1]); end
      n_tests++; if (wp1[1] !== 1'b0) begin n_fail++; $display("FAIL sat_pulse step=%0d got=%b exp=0", k, wp1[1]); end
    end
    n_tests++; if (c1[3:0] !== 4'd1) begin n_fail++; $display("FAIL sat_ch0_hold got=%0d exp=1", c1[3:0]); end
    enable = 2'b00; saturate = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 2'b01; load_value = {4'd0, 4'd15};
    step();
    n_tests++; if (c1[3:0] !== 4'd15) begin n_fail++; $display("FAIL prio_pre got=%0d exp=15", c1[3:0]); end
    load = 2'b01; load_value = {4'd3, 4'd9}; enable = 2'b01; up = 2'b01; saturate = 1'b0;
    step();
    n_tests++; if (c1[3:0] !== 4'd9) begin n_fail++; $display("FAIL prio_load got=%0d exp=9", c1[3:0]); end
    n_tests++; if (wp1[0] !== 1'b0) begin n_fail++; $display("FAIL prio_pulse got=%b exp=0", wp1[0]); end
    n_tests++; if (c1[7:4] !== 4'd0) begin n_fail++; $display("FAIL prio_ch1 got=%0d exp=0", c1[7:4]); end
    load = 2'b00;
    step();
    n_tests++; if (c1[3:0] !== 4'd10) begin n_fail++; $display("FAIL prio_count got=%0d exp=10", c1[3:0]); end
    load = 2'b11; load_value = {4'd7, 4'd2};
    step();
    n_tests++; if (c1 !== 8'h72) begin n_fail++; $display("FAIL prio_both got=%h exp=72", c1); end
    load = 2'b00; enable = 2'b00;
  endtask

  task automatic test_async_reset();
    load = 2'b01; load_value = {4'd0, 4'd15};
    step();
    load = 2'b00; enable = 2'b01; up = 2'b01; saturate = 1'b0;
    step();
    n_tests++; if (wp1[0] !== 1'b1) begin n_fail++; $display("FAIL arst_prewrap got=%b exp=1", wp1[0]); end
    reset = 1'b1;
    #1;
    n_tests++; if (c1 !== 8'h55) begin n_fail++; $display("FAIL arst_count got=%h exp=55", c1); end
    n_tests++; if (wp1 !== 2'b00) begin n_fail++; $display("FAIL arst_pulse got=%b exp=00", wp1); end
    @(negedge clock);
    n_tests++; if (c1 !== 8'h55) begin n_fail++; $display("FAIL arst_hold got=%h exp=55", c1); end
    reset = 1'b0;
    step();
    n_tests++; if (c1[3:0] !== 4'd6) begin n_fail++; $display("FAIL arst_resume6 got=%0d exp=6", c1[3:0]); end
    step();
    n_tests++; if (c1[3:0] !== 4'd7) begin n_fail++; $display("FAIL arst_resume7 got=%0d exp=7", c1[3:0]); end
    n_tests++; if (wp1[0] !== 1'b0) begin n_fail++; $display("FAIL arst_resume_pulse got=%b exp=0", wp1[0]); end
    enable = 2'b00;
  endtask

  task automatic test_prescaler();
    reset = 1'b1; load = 2'b00; enable = 2'b00;
    #1;
    @(negedge clock);
    reset = 1'b0; enable = 2'b01; up = 2'b01; saturate = 1'b0;
    n_tests++; if (tick3 !== 1'b0) begin n_fail++; $display("FAIL pre_tick0 got=%b exp=0", tick3); end
    n_tests++; if (c3 !== 8'h00) begin n_fail++; $display("FAIL pre_count0 got=%h exp=00", c3); end
    for (int k = 1; k <= 12; k++) begin
      step();
      n_tests++; if (tick3 !== ((k % 3) == 2)) begin n_fail++; $display("FAIL pre_tick cyc=%0d got=%b exp=%b", k, tick3, ((k % 3) == 2)); end
      n_tests++; if (c3[3:0] !== 4'(k / 3)) begin n_fail++; $display("FAIL pre_count cyc=%0d got=%0d exp=%0d", k, c3[3:0], k / 3); end
    end
    n_tests++; if (c3[7:4] !== 4'd0) begin n_fail++; $display("FAIL pre_ch1 got=%0d exp=0", c3[7:4]); end
    enable = 2'b00;
  endtask

  initial begin
    reset = 1'b0; load = 2'b00; load_value = 8'h00;
    up = 2'b00; enable = 2'b00; saturate = 1'b0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_priority();
    test_async_reset();
    test_prescaler();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
Name: counter_bank

Overview:
- Parametrised successor to the single-channel load/up/down counter.
- N independent up/down counters share one prescaler tick.
- Each counter has per-channel load, direction and enable, a wrap or saturate mode, and terminal-count flags.
- Sits between input-event logic (buttons, pointer coordinates) and display/timing consumers that need several synchronised counters.

Parameters:
- WIDTH, 16, bit width of each counter.
- CHANNELS, 2, number of independent counters.
- PRESCALE, 1, tick period in clock cycles; must be at least 1; 1 means every cycle.
- RESET_VALUE, 0, value of every counter after reset, WIDTH bits.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  CHANNELS  per-channel synchronous load request.
- load_value  input  CHANNELS*WIDTH  load data; channel i occupies bits [i*WIDTH +: WIDTH].
- up  input  CHANNELS  direction: 1 increments, 0 decrements.
- enable  input  CHANNELS  per-channel count enable.
- saturate  input  1  mode: 0 wraps modulo 2^WIDTH, 1 clamps at the limits.
- count  output  CHANNELS*WIDTH  current counter values, same packing as load_value.
- at_max  output  CHANNELS  count[i] equals all-ones; combinational from count.
- at_min  output  CHANNELS  count[i] equals zero; combinational from count.
- wrap_pulse  output  CHANNELS  registered one-cycle pulse after a wrap event.
- tick  output  1  prescaler strobe; combinational from the prescaler state.

Behaviour:
Reset:
- While reset is high: every count = RESET_VALUE, prescaler state = 0, wrap_pulse = 0.
- Consequently tick = 1 if PRESCALE == 1, else 0.
- at_max and at_min follow RESET_VALUE.
- Asserting reset mid-operation discards any pending load or count immediately, without waiting for a clock edge.

Prescaler:
- State p counts 0..PRESCALE-1 and wraps to 0.
- tick = (p == PRESCALE-1).
- With PRESCALE=3, tick is high on the 3rd, 6th, ... cycle after reset release.
- The prescaler runs free; it is unaffected by load, enable or saturate.

Per-channel update at each rising edge, in priority order:
1. If load[i]: count[i] <= load_value[i]. This ignores tick, enable, up and saturate, and wrap_pulse[i] <= 0.
2. Else if enable[i] & tick:
   - up=1, count<max: count+1.
   - up=1, count=max, wrap mode: count becomes 0 and wrap_pulse[i] <= 1.
   - up=1, count=max, saturate mode: count is held and wrap_pulse[i] <= 0.
   - up=0 mirrors the above at zero: wrap mode goes to all-ones with a pulse; saturate mode holds.
3. Otherwise: count[i] holds and wrap_pulse[i] <= 0.

Timing and width rules:
- Latency: one cycle from a sampled load or count condition to the new value on count.
- wrap_pulse is high for exactly one cycle: the cycle in which the wrapped value is first visible.
- Channels are fully independent; simultaneous loads or wraps on all channels are legal.
- Arithmetic is WIDTH-bit unsigned. No carry leaves a channel.
- saturate is sampled every edge; changing it mid-run affects only subsequent steps.
- PRESCALE=1 must not create a zero-width prescaler register; implement tick as constant 1.

Decomposition:
- Package counter_bank_pkg:
  - function computing the prescaler width, ceil(log2(PRESCALE)), minimum 1;
  - parameter checks (PRESCALE >= 1, WIDTH >= 1).
- Sub-module counter_bank_channel: one counter holding load/step/saturate/wrap logic and the at_max/at_min/wrap_pulse outputs.
- Top level: prescaler plus a generate loop of CHANNELS instances, with the packed buses sliced per instance.

Test Plan:
- Reset: WIDTH=4, CHANNELS=2, RESET_VALUE=5; assert reset between clock edges -> count={5,5} without a clock edge, at_min=0, wrap_pulse=0.
- Wrap up: ch0 load 14, then up=1, enable=1, saturate=0, PRESCALE=1 -> 15, 0 (wrap_pulse[0]=1 for that cycle only), 1; ch1 with enable=0 holds.
- Saturate down: ch1 load 1, up=0, saturate=1 -> 1, 0, 0, 0; at_min[1]=1; wrap_pulse[1] never asserts.
- Prescaler: PRESCALE=3, ch0 enable, up from 0 -> count advances once every 3 cycles, coincident with tick; reaches 4 after 12 cycles.
- Load priority: load[0]=1 with value 9 on the same edge as enable&tick&up at count=15 -> count=9, no wrap_pulse.
- Async reset mid-count: assert reset half a cycle after a wrap edge -> count returns to RESET_VALUE and wrap_pulse drops before the next clock edge; counting resumes correctly after release.
